check_node_unit: RTL and testbench
==================================

Name: check_node_unit

Overview:
- Min-sum check-node processor that sits directly downstream of the cyclic shifter's VTC output path. It accepts one row's worth of shifted variable-to-check words, one column block per beat, D lanes wide.
- It then emits one check-to-variable word per column block. These words return through the shifter's CTV path to the variable nodes.
- Lane format on both sides is sign-magnitude: MSB is the sign, the remaining bits are the magnitude. A null block (sign 0, magnitude all ones) is therefore neutral for the min search.

Parameters:
- data_w, 8: CTV word width per lane (1 sign + data_w-1 magnitude bits).
- ext_w, 3: extra VTC width bits per lane.
- D, 5: lanes (expansion factor).
- deg_max, 8: maximum column blocks per row.
- idx_w, 3: column index width; must satisfy 2^idx_w >= deg_max.
- Derived, not a parameter: temp_w = data_w + ext_w (VTC lane width).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- vtc_valid, input, 1: VTC beat present.
- vtc_last, input, 1: current beat is the last column block of the row.
- vtc, input, temp_w*D: shifted VTC lanes; lane i occupies bits [i*temp_w +: temp_w].
- vtc_ready, output, 1: block accepts a VTC beat.
- ctv_valid, output, 1: CTV word valid.
- ctv_last, output, 1: current CTV word is the last of the row.
- ctv_col, output, idx_w: column index of the current CTV word.
- ctv, output, data_w*D: CTV lanes; lane i occupies bits [i*data_w +: data_w].
- ctv_ready, input, 1: consumer takes the CTV word.
- busy, output, 1: a row is in progress (not IDLE).

Behaviour:
- Reset: asynchronous on rst_n low.
  - State → IDLE; column counter and degree register → 0.
  - Per lane: min1 and min2 → all ones (temp_w-1 bits), min1_idx → 0, sign_acc → 0.
  - Sign store → 0.
  - Outputs: ctv_valid=0, ctv_last=0, ctv_col=0, ctv=0, busy=0, vtc_ready=1.
  - Reset mid-row discards the row; no partial output.
- States: IDLE, ACC, EMIT.
  - vtc_ready = (state != EMIT).
  - busy = (state != IDLE).
- Accept: a beat is accepted when vtc_valid && vtc_ready.
  - Beat accepted in IDLE: initialise all per-lane trackers as if freshly reset, then fold the beat in as column 0, counter → 1. Next state is ACC, or EMIT if vtc_last.
  - Beat accepted in ACC: fold the beat in with column index = counter, counter += 1.
  - Forced end of row: when vtc_last=1 or counter+1 == deg_max, latch degree = counter+1 and go to EMIT next cycle. If vtc_last is absent at deg_max, the row is still closed.
- Fold, per lane i with sign s and magnitude m (temp_w-1 bits):
  - sign_acc ^= s; store s at [col][i].
  - If m < min1: min2 ← min1, min1 ← m, min1_idx ← col.
  - Else if m < min2: min2 ← m.
  - Tie rule: an equal magnitude never replaces min1; the earliest column keeps min1_idx.
- Fold latency: trackers update on the accepting edge; no bubbles between beats.
- EMIT: output column counter k starts at 0.
  - ctv_valid=1 is combinational from registered state; ctv, ctv_col=k and ctv_last=(k==degree-1) are held stable while ctv_ready=0.
  - On ctv_valid && ctv_ready: k += 1. If ctv_last, go to IDLE; the first new VTC beat is accepted the following cycle at the earliest.
- CTV lane i for column k:
  - sign = sign_acc[i] ^ stored_sign[k][i].
  - mag = (k == min1_idx[i]) ? min2[i] : min1[i], saturated to 2^(data_w-1)-1.
- Degree-1 row: min2 stays all ones, so the output magnitude saturates to its maximum; this is legal.
- No combinational path from vtc to ctv.
- First CTV word appears on the cycle after the last VTC beat is accepted.

Test Plan:
- Basic row, D=5, all lanes equal, 3 beats:
  - Stimulus: magnitudes 20, 5, 9; signs 0, 1, 0; vtc_last on beat 3.
  - Required response, in order: col0 = sign 1, mag 5; col1 = sign 0, mag 9; col2 = sign 1, mag 5. ctv_last on col2; busy drops the cycle after.
- Tie: magnitudes 7, 7, 12 → min1_idx=0; outputs 7, 7, 7 (col0 receives min2=7).
- Saturation: magnitudes 300, 200 (data_w=8) → both outputs 127; signs correct.
- Null blocks: beats of {0, all ones} mixed with real magnitudes 3 and 6 → null columns receive mag 3, the column holding 3 receives 6; signs unaffected by null blocks.
- Backpressure and overflow:
  - ctv_ready held low for 4 cycles mid-EMIT → word stable, vtc_ready=0, a VTC beat offered during this time is not accepted.
  - 8 beats without vtc_last → row closes at deg_max, 8 CTV words emitted.
- Reset mid-row: rst_n low after beat 2 of a 4-beat row → outputs at reset values immediately; a new 2-beat row afterwards produces only its own correct results.

Source files
------------

// File: rtl/check_node_unit.sv
// Min-sum check-node processor: folds one row of shifted VTC blocks into per-lane
// min1/min2/sign trackers, then emits one CTV word per column block.
module check_node_unit #(
    parameter int unsigned data_w  = 8,
    parameter int unsigned ext_w   = 3,
    parameter int unsigned D       = 5,
    parameter int unsigned deg_max = 8,
    parameter int unsigned idx_w   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vtc_valid,
    input  logic                          vtc_last,
    input  logic [(data_w+ext_w)*D-1:0]   vtc,
    output logic                          vtc_ready,
    output logic                          ctv_valid,
    output logic                          ctv_last,
    output logic [idx_w-1:0]              ctv_col,
    output logic [data_w*D-1:0]           ctv,
    input  logic                          ctv_ready,
    output logic                          busy
);

    localparam int unsigned temp_w = data_w + ext_w;
    localparam int unsigned mag_w  = temp_w - 1;
    localparam int unsigned out_w  = data_w - 1;
    localparam logic [mag_w-1:0] sat_max  = mag_w'((1 << out_w) - 1);
    localparam logic [idx_w-1:0] last_col = idx_w'(deg_max - 1);

    typedef enum logic [1:0] {StIdle, StAcc, StEmit} state_e;

    state_e            state_q, state_d;
    logic [idx_w-1:0]  cnt_q, cnt_d;
    logic [idx_w-1:0]  deg_last_q, deg_last_d;  // degree - 1
    logic [idx_w-1:0]  k_q, k_d;
    logic [mag_w-1:0]  min1_q [D];
    logic [mag_w-1:0]  min1_d [D];
    logic [mag_w-1:0]  min2_q [D];
    logic [mag_w-1:0]  min2_d [D];
    logic [idx_w-1:0]  idx_q  [D];
    logic [idx_w-1:0]  idx_d  [D];
    logic [D-1:0]      sacc_q, sacc_d;
    logic [D-1:0]      sstore_q [deg_max];

    logic              accept, row_end;
    logic [idx_w-1:0]  col;
    logic [mag_w-1:0]  in_mag  [D];
    logic [D-1:0]      in_sgn;
    logic [mag_w-1:0]  base1   [D];
    logic [mag_w-1:0]  base2   [D];
    logic [idx_w-1:0]  base_idx[D];
    logic [D-1:0]      base_sgn;
    logic [mag_w-1:0]  sel_mag [D];
    logic [out_w-1:0]  out_mag [D];

    assign accept  = vtc_valid && vtc_ready;
    assign col     = (state_q == StIdle) ? '0 : cnt_q;
    assign row_end = vtc_last || (col == last_col);

    // A row starting from IDLE folds against fresh trackers, not the previous row's.
    for (genvar i = 0; i < D; i++) begin : g_lane
        assign in_sgn[i]   = vtc[i*temp_w + temp_w - 1];
        assign in_mag[i]   = vtc[i*temp_w +: mag_w];
        assign base1[i]    = (state_q == StIdle) ? '1 : min1_q[i];
        assign base2[i]    = (state_q == StIdle) ? '1 : min2_q[i];
        assign base_idx[i] = (state_q == StIdle) ? '0 : idx_q[i];
        assign base_sgn[i] = (state_q == StIdle) ? 1'b0 : sacc_q[i];
        assign sel_mag[i]  = (k_q == idx_q[i]) ? min2_q[i] : min1_q[i];
        assign out_mag[i]  = (sel_mag[i] > sat_max) ? sat_max[out_w-1:0]
                                                    : sel_mag[i][out_w-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StAcc: begin
                if (accept) state_d = row_end ? StEmit : StAcc;
            end
            StEmit: begin
                if (ctv_ready && (k_q == deg_last_q)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        deg_last_d = deg_last_q;
        k_d        = k_q;
        sacc_d     = sacc_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        idx_d      = idx_q;
        if (accept) begin
            cnt_d = col + idx_w'(1);
            if (row_end) deg_last_d = col;
            sacc_d = base_sgn ^ in_sgn;
            for (int i = 0; i < D; i++) begin
                // Strict compares: ties never displace min1, earliest column wins.
                if (in_mag[i] < base1[i]) begin
                    min1_d[i] = in_mag[i];
                    min2_d[i] = base1[i];
                    idx_d[i]  = col;
                end else if (in_mag[i] < base2[i]) begin
                    min1_d[i] = base1[i];
                    min2_d[i] = in_mag[i];
                    idx_d[i]  = base_idx[i];
                end else begin
                    min1_d[i] = base1[i];
                    min2_d[i] = base2[i];
                    idx_d[i]  = base_idx[i];
                end
            end
        end
        if ((state_q == StEmit) && ctv_ready) begin
            k_d = (k_q == deg_last_q) ? '0 : k_q + idx_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            deg_last_q <= '0;
            k_q        <= '0;
            sacc_q     <= '0;
            for (int i = 0; i < D; i++) begin
                min1_q[i] <= '1;
                min2_q[i] <= '1;
                idx_q[i]  <= '0;
            end
            for (int c = 0; c < deg_max; c++) sstore_q[c] <= '0;
        end else begin
            cnt_q      <= cnt_d;
            deg_last_q <= deg_last_d;
            k_q        <= k_d;
            sacc_q     <= sacc_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            idx_q      <= idx_d;
            if (accept) sstore_q[col] <= in_sgn;
        end
    end

    always_comb begin
        vtc_ready = (state_q != StEmit);
        busy      = (state_q != StIdle);
        ctv_valid = (state_q == StEmit);
        ctv_last  = ctv_valid && (k_q == deg_last_q);
        ctv_col   = k_q;
        ctv       = '0;
        if (ctv_valid) begin
            for (int i = 0; i < D; i++) begin
                ctv[i*data_w +: data_w] = {sacc_q[i] ^ sstore_q[k_q][i], out_mag[i]};
            end
        end
    end

endmodule

// File: tb/tb_check_node_unit.sv
// Bench for check_node_unit: directed rows plus random rows, checked against a
// min-over-other-columns reference model.
module tb_check_node_unit;

    localparam int unsigned DW  = 8;
    localparam int unsigned EW  = 3;
    localparam int unsigned D   = 5;
    localparam int unsigned DEG = 8;
    localparam int unsigned IW  = 3;
    localparam int unsigned TW  = DW + EW;
    localparam int unsigned MW  = TW - 1;
    localparam int unsigned OW  = DW - 1;
    localparam int NULLM = (1 << MW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              vtc_valid;
    logic              vtc_last;
    logic [TW*D-1:0]   vtc;
    logic              vtc_ready;
    logic              ctv_valid;
    logic              ctv_last;
    logic [IW-1:0]     ctv_col;
    logic [DW*D-1:0]   ctv;
    logic              ctv_ready;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int mag_t [DEG][D];
    bit sgn_t [DEG][D];

    check_node_unit #(
        .data_w (DW),
        .ext_w  (EW),
        .D      (D),
        .deg_max(DEG),
        .idx_w  (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vtc_valid(vtc_valid),
        .vtc_last (vtc_last),
        .vtc      (vtc),
        .vtc_ready(vtc_ready),
        .ctv_valid(ctv_valid),
        .ctv_last (ctv_last),
        .ctv_col  (ctv_col),
        .ctv      (ctv),
        .ctv_ready(ctv_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each output lane: XOR of the other columns' signs, min of the other columns' magnitudes.
    function automatic logic [DW*D-1:0] exp_ctv(input int k, input int n);
        logic [DW*D-1:0] v;
        int m;
        bit s;
        v = '0;
        for (int i = 0; i < D; i++) begin
            m = NULLM;
            s = 1'b0;
            for (int j = 0; j < n; j++) begin
                if (j != k) begin
                    if (mag_t[j][i] < m) m = mag_t[j][i];
                    s ^= sgn_t[j][i];
                end
            end
            if (m > (1 << OW) - 1) m = (1 << OW) - 1;
            v[i*DW +: DW] = {s, OW'(m)};
        end
        return v;
    endfunction

    task automatic fill_equal(input int c, input bit s, input int m);
        for (int i = 0; i < D; i++) begin
            sgn_t[c][i] = s;
            mag_t[c][i] = m;
        end
    endtask

    task automatic send_beat(input int c, input bit last);
        int waited;
        vtc_valid = 1'b1;
        vtc_last  = last;
        for (int i = 0; i < D; i++) vtc[i*TW +: TW] = {sgn_t[c][i], MW'(mag_t[c][i])};
        waited = 0;
        @(negedge clk);
        while (!vtc_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) check("vtc_ready_timeout", 64'(vtc_ready), 64'd1);
        @(posedge clk);
        #1;
        vtc_valid = 1'b0;
        vtc_last  = 1'b0;
    endtask

    task automatic collect_row(input int n);
        int waited;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) check("first_ctv_latency", 64'(ctv_valid), 64'd1);
            waited = 0;
            while (!ctv_valid && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            check("ctv_valid", 64'(ctv_valid), 64'd1);
            check("ctv_col", 64'(ctv_col), 64'(k));
            check("ctv_last", 64'(ctv_last), 64'(k == n - 1));
            check("ctv_word", 64'(ctv), 64'(exp_ctv(k, n)));
        end
        @(negedge clk);
        check("busy_after_row", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input int n, input bit use_last);
        for (int c = 0; c < n; c++) send_beat(c, use_last && (c == n - 1));
        collect_row(use_last ? n : DEG);
    endtask

    task automatic check_reset_outputs();
        check("rst_ctv_valid", 64'(ctv_valid), 64'd0);
        check("rst_ctv_last", 64'(ctv_last), 64'd0);
        check("rst_ctv_col", 64'(ctv_col), 64'd0);
        check("rst_ctv", 64'(ctv), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_vtc_ready", 64'(vtc_ready), 64'd1);
    endtask

    initial begin
        int n;
        bit ul;
        rst_n     = 1'b0;
        vtc_valid = 1'b0;
        vtc_last  = 1'b0;
        vtc       = '0;
        ctv_ready = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic row: expect (1,5) (0,9) (1,5).
        fill_equal(0, 1'b0, 20);
        fill_equal(1, 1'b1, 5);
        fill_equal(2, 1'b0, 9);
        run_row(3, 1'b1);

        // Tie on magnitude 7: every column sees 7.
        fill_equal(0, 1'b1, 7);
        fill_equal(1, 1'b0, 7);
        fill_equal(2, 1'b1, 12);
        run_row(3, 1'b1);

        // Saturation to 127.
        fill_equal(0, 1'b1, 300);
        fill_equal(1, 1'b0, 200);
        run_row(2, 1'b1);

        // Null blocks mixed with 3 and 6.
        fill_equal(0, 1'b0, NULLM);
        fill_equal(1, 1'b1, 3);
        fill_equal(2, 1'b0, NULLM);
        fill_equal(3, 1'b1, 6);
        run_row(4, 1'b1);

        // Degree-1 row saturates.
        fill_equal(0, 1'b1, 4);
        run_row(1, 1'b1);

        // Backpressure: word 0 held for 4 cycles, an offered VTC beat is refused.
        fill_equal(0, 1'b0, 40);
        fill_equal(1, 1'b1, 11);
        fill_equal(2, 1'b1, 25);
        ctv_ready = 1'b0;
        for (int c = 0; c < 3; c++) send_beat(c, c == 2);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("bp_ctv_valid", 64'(ctv_valid), 64'd1);
            check("bp_ctv_col", 64'(ctv_col), 64'd0);
            check("bp_ctv_word", 64'(ctv), 64'(exp_ctv(0, 3)));
            check("bp_vtc_ready", 64'(vtc_ready), 64'd0);
            if (t == 1) begin
                vtc_valid = 1'b1;
                vtc_last  = 1'b1;
                vtc       = '0;
            end
        end
        @(posedge clk);
        #1;
        vtc_valid = 1'b0;
        vtc_last  = 1'b0;
        ctv_ready = 1'b1;
        collect_row(3);

        // Eight beats without vtc_last: row closes at deg_max.
        for (int c = 0; c < DEG; c++) fill_equal(c, bit'(c % 3 == 0), 50 - 3 * c);
        run_row(DEG, 1'b0);

        // Reset after beat 2 of a 4-beat row, then a clean 2-beat row.
        for (int c = 0; c < 4; c++) fill_equal(c, 1'b1, 2 + c);
        send_beat(0, 1'b0);
        send_beat(1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_equal(0, 1'b1, 33);
        fill_equal(1, 1'b0, 17);
        run_row(2, 1'b1);

        // Random rows with per-lane variety and frequent small/tied magnitudes.
        for (int r = 0; r < 10; r++) begin
            n  = $urandom_range(1, DEG);
            ul = (n < DEG) ? 1'b1 : bit'($urandom_range(0, 1));
            for (int c = 0; c < n; c++) begin
                for (int i = 0; i < D; i++) begin
                    sgn_t[c][i] = bit'($urandom_range(0, 1));
                    mag_t[c][i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15)
                                                              : $urandom_range(0, NULLM);
                end
            end
            run_row(n, ul);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
